// File: rtl/pio_pkg.sv
// Shared definitions for the input PIO: register word addresses, edge-type
// encodings and the synchronizer warm-up length.
package pio_pkg;

    // Word addresses on the Avalon-MM slave
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // EDGE_TYPE parameter encodings
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Clocks after reset before the synchronizer and d1 hold real input data.
    function automatic int unsigned warm_cycles(input int unsigned sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchronizer and per-bit edge detector.
//  clk, reset_n : system clock, asynchronous active-low reset
//  in_port      : asynchronous board inputs
//  data_reg     : synchronized inputs (last synchronizer stage)
//  edge_pulse   : one-clock pulse per bit on the selected edge type,
//                 suppressed until the synchronizer has warmed up
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned EDGE_TYPE   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data_reg,
    output logic [WIDTH-1:0] edge_pulse
);

    localparam int unsigned WARM_MAX  = warm_cycles(SYNC_STAGES);
    localparam logic [2:0]  WARM_DONE = 3'(WARM_MAX);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  d1_q;
    logic [2:0]                        warm_q;

    assign data_reg = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            d1_q   <= '0;
            warm_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            d1_q <= sync_q[SYNC_STAGES-1];
            if (warm_q != WARM_DONE) begin
                warm_q <= warm_q + 3'd1;
            end
        end
    end

    // Gated until the chain and d1 carry sampled data, so the transition from
    // the reset value to the first real sample is not taken as an edge.
    always_comb begin
        edge_pulse = '0;
        if (warm_q == WARM_DONE) begin
            if (EDGE_TYPE == EDGE_RISE) begin
                edge_pulse = data_reg & ~d1_q;
            end else if (EDGE_TYPE == EDGE_FALL) begin
                edge_pulse = ~data_reg & d1_q;
            end else begin
                edge_pulse = data_reg ^ d1_q;
            end
        end
    end

endmodule

// File: rtl/avalon_input_pio_irq.sv
// Avalon-MM slave input PIO with per-bit edge capture and a level interrupt.
//  clk, reset_n : system clock, asynchronous active-low reset
//  address      : word address (0 data, 1 zero, 2 irq mask, 3 edge capture)
//  chipselect   : slave select
//  write_n      : active-low write strobe
//  writedata    : write data
//  in_port      : asynchronous board inputs
//  readdata     : registered read data, one clock after select
//  irq          : registered level interrupt, |(edgecap & mask)
module avalon_input_pio_irq
    import pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      EDGE_TYPE   = 1,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] edge_pulse;

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      readdata_q, readdata_d;
    logic [31:0]      rd_mux;
    logic             irq_q;
    logic             wr_en;
    logic             unused_wdata;

    // Upper write-data bits are don't-care when WIDTH < 32.
    assign unused_wdata = ^writedata;

    pio_sync_edge #(
        .WIDTH      (WIDTH),
        .EDGE_TYPE  (EDGE_TYPE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .data_reg  (data_reg),
        .edge_pulse(edge_pulse)
    );

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        mask_d     = mask_q;
        clear_bits = '0;
        if (wr_en && (address == ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGE)) begin
            clear_bits = writedata[WIDTH-1:0];
        end
        // Set after clear: an edge arriving with a clear of the same bit survives.
        edgecap_d = (edgecap_q & ~clear_bits) | edge_pulse;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = data_reg;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecap_q;
            default:   rd_mux = '0;
        endcase
        readdata_d = chipselect ? rd_mux : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= RESET_MASK;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= |(edgecap_q & mask_q);
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_input_pio_irq.sv
module tb_avalon_input_pio_irq;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned EDGE_TYPE = 1;
    localparam int          S         = 2;
    localparam logic [WIDTH-1:0] RESET_MASK = '0;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    int n_cmp  = 0;
    int n_fail = 0;

    avalon_input_pio_irq #(
        .WIDTH      (WIDTH),
        .EDGE_TYPE  (EDGE_TYPE),
        .SYNC_STAGES(S),
        .RESET_MASK (RESET_MASK)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: the synchronized value is simply the input sampled S
    // clocks ago; edges compare that value with the one a clock earlier.
    logic [WIDTH-1:0] q_in[$];
    logic [WIDTH-1:0] m_data, m_prev, m_mask, m_cap;
    logic [31:0]      m_rd;
    logic             m_irq;
    int               m_clks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] edge_of(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] prev);
        if (EDGE_TYPE == 0) return cur & ~prev;
        if (EDGE_TYPE == 1) return ~cur & prev;
        return cur ^ prev;
    endfunction

    task automatic model_reset();
        q_in.delete();
        m_data = '0;
        m_prev = '0;
        m_mask = RESET_MASK;
        m_cap  = '0;
        m_rd   = '0;
        m_irq  = 1'b0;
        m_clks = 0;
    endtask

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic step();
        logic [WIDTH-1:0] pulse, clr;
        logic [31:0]      rd_n;
        logic             irq_n;
        @(posedge clk);
        pulse = (m_clks >= S + 1) ? edge_of(m_data, m_prev) : '0;
        irq_n = |(m_cap & m_mask);
        rd_n  = m_rd;
        if (chipselect) begin
            case (address)
                2'd0:    rd_n = 32'(m_data);
                2'd2:    rd_n = 32'(m_mask);
                2'd3:    rd_n = 32'(m_cap);
                default: rd_n = 32'd0;
            endcase
        end
        clr = '0;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[WIDTH-1:0];
        if (chipselect && !write_n && address == 2'd3) clr = writedata[WIDTH-1:0];
        m_cap  = (m_cap & ~clr) | pulse;
        m_prev = m_data;
        q_in.push_back(in_port);
        if (q_in.size() > S) q_in = q_in[1:$];
        m_data = (q_in.size() == S) ? q_in[0] : '0;
        if (m_clks < S + 1) m_clks++;
        m_rd  = rd_n;
        m_irq = irq_n;
        @(negedge clk);
        check("model_readdata", readdata, m_rd);
        check("model_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic bus(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
    endtask

    task automatic idle();
        bus(1'b0, 1'b1, 2'd0, 32'd0);
    endtask

    task automatic read_reg(input logic [1:0] a);
        bus(1'b1, 1'b1, a, 32'd0);
        step();
        idle();
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] wd);
        bus(1'b1, 1'b0, a, wd);
        step();
        idle();
    endtask

    // Asynchronous reset mid-cycle, released at the next falling edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        in_port = 4'hF;
        idle();
        model_reset();
        #3;
        check("init_readdata", readdata, 32'd0);
        check("init_irq", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // 1: held-high input reads back through the synchronizer
        repeat (4) step();
        read_reg(2'd0);
        check("t1_data", readdata, 32'h0000_000F);
        read_reg(2'd3);
        check("t1_edgecap", readdata, 32'd0);
        check("t1_irq", 32'(irq), 32'd0);
        read_reg(2'd1);
        check("t1_addr1", readdata, 32'd0);

        // 2: falling edge on bit 0 with mask 0x1
        write_reg(2'd2, 32'h1);
        in_port = 4'hE;
        repeat (S + 1) step();
        check("t2_irq_early", 32'(irq), 32'd0);
        step();
        check("t2_irq", 32'(irq), 32'd1);
        read_reg(2'd3);
        check("t2_edgecap", readdata, 32'h1);

        // 3: W1C clear, then a zero write leaves capture intact
        write_reg(2'd3, 32'h1);
        check("t3_irq_lag", 32'(irq), 32'd1);
        step();
        check("t3_irq_clr", 32'(irq), 32'd0);
        read_reg(2'd3);
        check("t3_edgecap_clr", readdata, 32'd0);
        in_port = 4'hF;
        repeat (S + 2) step();
        in_port = 4'hE;
        repeat (S + 2) step();
        check("t3_irq_again", 32'(irq), 32'd1);
        write_reg(2'd3, 32'h0);
        read_reg(2'd3);
        check("t3_noclear", readdata, 32'h1);

        // 4: clear collides with a new edge on the same bit
        in_port = 4'hF;
        repeat (S + 2) step();
        in_port = 4'hE;
        repeat (S) step();
        write_reg(2'd3, 32'h1);
        step();
        check("t4_irq", 32'(irq), 32'd1);
        read_reg(2'd3);
        check("t4_edgecap", readdata, 32'h1);

        // 5: input low from reset produces no capture
        in_port = 4'h0;
        do_reset();
        repeat (S + 4) step();
        check("t5_irq", 32'(irq), 32'd0);
        read_reg(2'd3);
        check("t5_edgecap", readdata, 32'd0);

        // 6: edges on all bits with mask 0, then unmask bit 3, then reset
        in_port = 4'hF;
        repeat (S + 2) step();
        in_port = 4'h0;
        repeat (S + 2) step();
        read_reg(2'd3);
        check("t6_edgecap", readdata, 32'hF);
        check("t6_irq_masked", 32'(irq), 32'd0);
        write_reg(2'd2, 32'h8);
        step();
        check("t6_irq", 32'(irq), 32'd1);
        read_reg(2'd3);
        do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = WIDTH'($urandom);
            bus(1'($urandom), 1'($urandom), 2'($urandom), $urandom);
            if ($urandom_range(0, 249) == 0) do_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
